// File: rtl/conv1_stream_core_if.sv
// rtl/conv1_stream_core_if.sv - pixel-in / feature-out stream bundle for conv1_stream_core
interface conv1_stream_core_if #(
    parameter int I_F_BW = 8,
    parameter int CI     = 1,
    parameter int CO     = 3,
    parameter int O_F_BW = 20
);
    logic                   i_in_valid;
    logic [CI*I_F_BW-1:0]   i_in_fmap;
    logic                   o_ot_valid;
    logic [CO*O_F_BW-1:0]   o_ot_fmap;

    // pixel feeder side: drives pixels, observes results
    modport master (
        output i_in_valid,
        output i_in_fmap,
        input  o_ot_valid,
        input  o_ot_fmap
    );

    // convolution core side
    modport slave (
        input  i_in_valid,
        input  i_in_fmap,
        output o_ot_valid,
        output o_ot_fmap
    );
endinterface

// File: rtl/conv1_stream_core.sv
// rtl/conv1_stream_core.sv - KXxKY valid-padding convolution, bias and ReLU over a raster pixel stream
module conv1_stream_core #(
    parameter int I_F_BW = 8,
    parameter int KX     = 5,
    parameter int KY     = 5,
    parameter int W_BW   = 8,
    parameter int B_BW   = 8,
    parameter int CI     = 1,
    parameter int CO     = 3,
    parameter int IX     = 28,
    parameter int IY     = 28,
    parameter int AK_BW  = 21,
    parameter int ACI_BW = 21,
    parameter int AB_BW  = 21,
    parameter int AR_BW  = 20,
    parameter int O_F_BW = 20
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [CO*CI*KX*KY*W_BW-1:0]    i_cnn_weight,
    input  logic [CO*B_BW-1:0]             i_cnn_bias,
    conv1_stream_core_if.slave             strm
);
    localparam int XW = $clog2(IX);
    localparam int YW = $clog2(IY);
    localparam int NT = KX * KY;

    logic [XW-1:0]         x_cnt;
    logic [YW-1:0]         y_cnt;
    logic [I_F_BW-1:0]     pix;
    logic                  win_done;

    logic [I_F_BW-1:0]     lb      [KY-1][IX];
    logic [I_F_BW-1:0]     col     [KY];
    logic [I_F_BW-1:0]     win     [KY][KX];
    logic [I_F_BW-1:0]     win_nxt [KY][KX];

    logic signed [AK_BW-1:0]  prod_nxt [CO][NT];
    logic signed [AK_BW-1:0]  prod     [CO][NT];
    logic signed [ACI_BW-1:0] sum_nxt  [CO];
    logic signed [ACI_BW-1:0] sum_q    [CO];
    logic [CO*O_F_BW-1:0]     out_nxt;

    logic v1, v2;

    // only channel 0 of the input word is used (CI=1)
    assign pix      = strm.i_in_fmap[I_F_BW-1:0];
    assign win_done = strm.i_in_valid && (x_cnt >= XW'(KX-1)) && (y_cnt >= YW'(KY-1));

    // raster position of the incoming pixel; wraps per line and per frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (strm.i_in_valid) begin
            if (x_cnt == XW'(IX-1)) begin
                x_cnt <= '0;
                y_cnt <= (y_cnt == YW'(IY-1)) ? '0 : y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    // new window column: oldest buffered row at the top, live pixel at the bottom
    always_comb begin
        col[KY-1] = pix;
        for (int k = 0; k < KY-1; k++) begin
            col[KY-2-k] = lb[k][x_cnt];
        end
    end

    // window as it will look after this pixel; products are taken from it directly
    always_comb begin
        for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX-1; kx++) begin
                win_nxt[ky][kx] = win[ky][kx+1];
            end
            win_nxt[ky][KX-1] = col[ky];
        end
    end

    // line buffers cascade one row down and the window shifts left on each valid pixel
    always_ff @(posedge clk) begin
        if (strm.i_in_valid) begin
            lb[0][x_cnt] <= pix;
            for (int k = 1; k < KY-1; k++) begin
                lb[k][x_cnt] <= lb[k-1][x_cnt];
            end
            win <= win_nxt;
        end
    end

    // unsigned pixel times signed weight, both widened to the accumulator width
    always_comb begin
        for (int co = 0; co < CO; co++) begin
            for (int t = 0; t < NT; t++) begin
                prod_nxt[co][t] =
                    $signed({{(AK_BW-I_F_BW){1'b0}}, win_nxt[t/KX][t%KX]}) *
                    $signed({{(AK_BW-W_BW){i_cnn_weight[(co*CI*NT+t)*W_BW+W_BW-1]}},
                             i_cnn_weight[(co*CI*NT+t)*W_BW +: W_BW]});
            end
        end
    end

    // stage 1: registered window products
    always_ff @(posedge clk) begin
        prod <= prod_nxt;
    end

    // adder tree over all taps of each channel
    always_comb begin
        for (int co = 0; co < CO; co++) begin
            sum_nxt[co] = '0;
            for (int t = 0; t < NT; t++) begin
                sum_nxt[co] = sum_nxt[co] + ACI_BW'(prod[co][t]);
            end
        end
    end

    // stage 2: registered kernel sums
    always_ff @(posedge clk) begin
        sum_q <= sum_nxt;
    end

    // bias add and ReLU per channel
    always_comb begin
        logic signed [AB_BW-1:0] biased;
        logic [AR_BW-1:0]        relu;
        out_nxt = '0;
        for (int co = 0; co < CO; co++) begin
            biased = AB_BW'(sum_q[co]) +
                     $signed({{(AB_BW-B_BW){i_cnn_bias[co*B_BW+B_BW-1]}}, i_cnn_bias[co*B_BW +: B_BW]});
            relu   = biased[AB_BW-1] ? '0 : biased[AR_BW-1:0];
            out_nxt[co*O_F_BW +: O_F_BW] = O_F_BW'(relu);
        end
    end

    // valid pipeline and stage 3 output register; data holds while no result is due
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1              <= 1'b0;
            v2              <= 1'b0;
            strm.o_ot_valid <= 1'b0;
            strm.o_ot_fmap  <= '0;
        end else begin
            v1              <= win_done;
            v2              <= v1;
            strm.o_ot_valid <= v2;
            if (v2) begin
                strm.o_ot_fmap <= out_nxt;
            end
        end
    end
endmodule

// File: tb/tb_conv1_stream_core.sv
// tb/tb_conv1_stream_core.sv - directed self-checking bench for conv1_stream_core
module tb_conv1_stream_core;
    localparam int CO = 3, KX = 5, KY = 5, W_BW = 8, B_BW = 8, O_F_BW = 20;
    localparam int IX = 28, IY = 28, OX = 24, NRES = 576;

    logic clk = 1'b0;
    logic reset_n;
    logic [CO*KX*KY*W_BW-1:0] wgt;
    logic [CO*B_BW-1:0]       bias;

    conv1_stream_core_if #(.I_F_BW(8), .CI(1), .CO(CO), .O_F_BW(O_F_BW)) strm();

    conv1_stream_core dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_cnn_weight (wgt),
        .i_cnn_bias   (bias),
        .strm         (strm)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int first_cyc = -1;
    int mark_cyc = 0;
    logic [CO*O_F_BW-1:0] res_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (strm.o_ot_valid === 1'b1) begin
            if (res_q.size() == 0) first_cyc = cyc;
            res_q.push_back(strm.o_ot_fmap);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    function automatic int pix(input int f, input int x, input int y);
        case (f)
            0: return x + y;
            1: return (x*3 + y*7 + 1) % 256;
            default: return 255;
        endcase
    endfunction

    // mode 0: zero weights, bias {5,-3,0}
    // mode 1: ch0 centre tap 1, ch1 top-left tap 2, ch2 bottom-right tap -1 with bias 100
    // mode 2: all weights 127, bias 127; mode 3: all weights -128, bias 0
    function automatic logic [CO*O_F_BW-1:0] expv(input int mode, input int f, input int ox, input int oy);
        int c0, c1, c2;
        case (mode)
            0: begin c0 = 5; c1 = 0; c2 = 0; end
            1: begin
                c0 = pix(f, ox+2, oy+2);
                c1 = 2 * pix(f, ox, oy);
                c2 = 100 - pix(f, ox+4, oy+4);
                if (c2 < 0) c2 = 0;
            end
            2: begin c0 = 809752; c1 = 809752; c2 = 809752; end
            default: begin c0 = 0; c1 = 0; c2 = 0; end
        endcase
        return {O_F_BW'(c2), O_F_BW'(c1), O_F_BW'(c0)};
    endfunction

    task automatic set_tap(input int co, input int ky, input int kx, input logic [7:0] v);
        wgt[((co*KY + ky)*KX + kx)*W_BW +: W_BW] = v;
    endtask

    task automatic set_mode(input int mode);
        wgt  = '0;
        bias = '0;
        case (mode)
            0: begin bias[0 +: 8] = 8'd5; bias[8 +: 8] = 8'hFD; end
            1: begin
                set_tap(0, 2, 2, 8'd1);
                set_tap(1, 0, 0, 8'd2);
                set_tap(2, 4, 4, 8'hFF);
                bias[16 +: 8] = 8'd100;
            end
            2: begin
                for (int i = 0; i < CO*KX*KY; i++) wgt[i*W_BW +: W_BW] = 8'd127;
                for (int c = 0; c < CO; c++) bias[c*B_BW +: B_BW] = 8'd127;
            end
            default: for (int i = 0; i < CO*KX*KY; i++) wgt[i*W_BW +: W_BW] = 8'h80;
        endcase
    endtask

    // drives up to npix pixels of frame f; optional random single-cycle bubbles
    task automatic send_frame(input int f, input bit gaps, input int npix);
        int n = 0;
        for (int y = 0; y < IY; y++) begin
            for (int x = 0; x < IX; x++) begin
                if (n < npix) begin
                    if (gaps && ($urandom_range(0, 1) == 1)) begin
                        @(posedge clk); #1;
                    end
                    strm.i_in_valid = 1'b1;
                    strm.i_in_fmap  = 8'(pix(f, x, y));
                    if (x == 4 && y == 4) mark_cyc = cyc;
                    @(posedge clk); #1;
                    strm.i_in_valid = 1'b0;
                    n++;
                end
            end
        end
    endtask

    task automatic drain();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic check_run(input string tag, input int mode, input int fa, input int fb, input int nf);
        int lim;
        chk($sformatf("%s_count", tag), res_q.size(), nf*NRES);
        lim = (res_q.size() < nf*NRES) ? res_q.size() : nf*NRES;
        for (int n = 0; n < lim; n++) begin
            int p = n % NRES;
            chk($sformatf("%s_res%0d", tag, n), res_q[n],
                expv(mode, (n < NRES) ? fa : fb, p % OX, p / OX));
        end
    endtask

    initial begin
        reset_n         = 1'b0;
        strm.i_in_valid = 1'b0;
        strm.i_in_fmap  = '0;
        set_mode(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", strm.o_ot_valid, 0);
        chk("rst_fmap", strm.o_ot_fmap, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // zero weights: bias only, plus first-result latency
        res_q.delete();
        first_cyc = -1;
        send_frame(1, 1'b0, IX*IY);
        drain();
        check_run("zero_w", 0, 1, 1, 1);
        chk("latency", first_cyc - mark_cyc, 3);

        // two back-to-back frames with different images
        set_mode(1);
        res_q.delete();
        send_frame(0, 1'b0, IX*IY);
        send_frame(1, 1'b0, IX*IY);
        drain();
        check_run("b2b", 1, 0, 1, 2);

        // same kernel, frame with random input bubbles
        res_q.delete();
        send_frame(0, 1'b1, IX*IY);
        drain();
        check_run("gaps", 1, 0, 0, 1);

        // largest positive sum
        set_mode(2);
        res_q.delete();
        send_frame(2, 1'b0, IX*IY);
        drain();
        check_run("max", 2, 2, 2, 1);

        // large negative sum clipped by ReLU
        set_mode(3);
        res_q.delete();
        send_frame(2, 1'b0, IX*IY);
        drain();
        check_run("relu", 3, 2, 2, 1);

        // reset in the middle of a frame, then a clean frame
        set_mode(1);
        res_q.delete();
        send_frame(0, 1'b0, 300);
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("midrst_valid%0d", i), strm.o_ot_valid, 0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        res_q.delete();
        @(posedge clk); #1;
        send_frame(1, 1'b0, IX*IY);
        drain();
        check_run("after_rst", 1, 1, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
